param_counter: RTL and testbench
================================

Name: param_counter

Overview:
- Parametrised, prescaled, modulo up/down counter. It is the next-generation counter for DE-series demo tops.
- It is driven by the board clock, with the active-low reset taken from a pushbutton.
- It adds a programmable modulus, direction control, synchronous load, a terminal-count pulse, and wrap / saturate / one-shot modes.
- Q drives LEDR or 7-segment decoders directly. Tc cascades into further counters, for example seconds into minutes.

Parameters:
- WIDTH, 10, width of count value Q.
- MAX, 1023, terminal value; count range 0..MAX. Legal range is 1 <= MAX <= 2**WIDTH-1; elaboration error otherwise.
- PRESCALE, 1, clock cycles per count step. Must be >= 1; 1 means step every enabled cycle.
- RESET_VAL, 0, value of Q after reset. Must be <= MAX.

Ports:
- Clock  input  1  system clock (CLOCK_50 at top level); all state changes on its rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- En  input  1  count enable; gates the prescaler and stepping.
- Up  input  1  direction: 1 = increment, 0 = decrement.
- Mode  input  2  count_mode_t: WRAP=0, SAT=1, ONESHOT=2; value 3 behaves as WRAP.
- Load  input  1  synchronous load strobe.
- D  input  WIDTH  load value.
- Q  output  WIDTH  current count, registered.
- Tc  output  1  terminal-count pulse, registered, one cycle wide.
- Done  output  1  high while the one-shot has finished (state DONE).

Behaviour:
- **Reset.**
  - Resetn=0 asynchronously forces Q=RESET_VAL, Tc=0, Done=0, prescaler count=0, state=RUN.
  - Release is synchronous to the next Clock edge.
- **Prescaler.**
  - Internal counter pc, 0..PRESCALE-1, advances only when En=1 and state=RUN.
  - tick = En & (pc==PRESCALE-1) & state==RUN; pc wraps to 0 on tick.
  - With PRESCALE=1, tick = En & state==RUN.
  - En=0 freezes pc; it is not cleared.
- **Terminal value.** term = MAX when Up=1, term = 0 when Up=0.
- **Step on tick, Q != term.** Q <= Q+1 (Up) or Q-1 (Down). Tc <= 0.
- **Step on tick, Q == term.** Tc <= 1 for exactly the next cycle, then:
  - WRAP: Q <= 0 (Up) or MAX (Down).
  - SAT: Q holds. Tc pulses again on every subsequent tick while Q remains at term.
  - ONESHOT: Q holds, state <= DONE, Done <= 1.
- **No tick.** Tc <= 0.
- **Load (highest priority, ignores En and state).**
  - Q <= (D > MAX) ? MAX : D.
  - pc <= 0; state <= RUN; Done <= 0; Tc <= 0.
- **State machine (two states).**
  - RUN -> DONE: tick at term in ONESHOT mode.
  - DONE -> RUN: on Load, or on the cycle after Mode != ONESHOT is sampled.
  - In DONE, ticks are suppressed and Q and pc are frozen.
- **Direction and mode changes.**
  - Up or Mode may change on any cycle; they are sampled at the edge where the step is evaluated.
  - Reversing direction at a terminal is legal. Example: Q=MAX with Up switched to 0 steps to MAX-1, no Tc.
- **Arithmetic.**
  - Unsigned, WIDTH bits.
  - No intermediate overflow, because wrap and saturate decisions use the Q==term compare, not a carry.
- **Simultaneous events.**
  - Load together with a tick: Load wins, no Tc.
  - Reset assertion mid-count overrides everything immediately.

Decomposition:
- Package counter_pkg holds:
  - typedef enum logic [1:0] count_mode_t {WRAP, SAT, ONESHOT}
  - typedef enum logic state_t {RUN, DONE}
- One sub-module, prescaler:
  - Parameter PRESCALE.
  - Ports Clock, Resetn, En, Clr, Tick.
  - Counter width $clog2(PRESCALE), minimum 1.
  - With PRESCALE=1 it reduces to Tick=En.

Test Plan:
All scenarios use WIDTH=4, MAX=9, PRESCALE=3, RESET_VAL=0 unless stated.
- **Reset and wrap up.** Hold Resetn=0, then release with En=1, Up=1, Mode=WRAP.
  - Q steps every 3 cycles: 0,1,…,9,0.
  - Tc is high for one cycle after the 9->0 step; Done=0 throughout.
- **Down wrap and saturate.**
  - Load D=2, Up=0, WRAP: Q goes 2,1,0,9 with Tc on the 0->9 step.
  - Repeat with SAT: Q sticks at 0, and Tc pulses every 3 cycles.
- **One-shot.** Load D=7, Up=1, Mode=ONESHOT.
  - Q goes 7,8,9; Tc pulses once; Done=1; Q stays 9 for 30+ cycles.
  - Then Load D=0: Done=0 and counting resumes.
- **Load clamp and priority.**
  - Load D=15: Q=9.
  - Assert Load D=4 on the same cycle as a tick at Q=9 (WRAP): Q=4 and Tc=0.
- **Enable freeze.**
  - Drop En for 10 cycles mid-prescale: Q and pc are held.
  - On resuming, the step occurs after the remaining prescale cycles, not a full 3.
- **Async reset mid-run.**
  - Pull Resetn low between Clock edges at Q=6, Done=0: Q=0 and Tc=0 before the next edge.
  - Repeat in DONE state: Done clears immediately.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types for the prescaled modulo up/down counter.
package counter_pkg;

    typedef enum logic [1:0] {
        WRAP    = 2'd0,
        SAT     = 2'd1,
        ONESHOT = 2'd2
    } count_mode_t;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

endpackage

// File: rtl/prescaler.sv
// Divides enabled cycles by PRESCALE; Tick marks the last cycle of each period.
module prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic En,
    input  logic Clr,
    output logic Tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    generate
        if (PRESCALE == 1) begin : g_bypass
            logic unused_inputs;
            assign unused_inputs = &{1'b0, Clock, Resetn, Clr};
            assign Tick = En;
        end else begin : g_count
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
            logic [PW-1:0] pc_q;
            logic [PW-1:0] pc_d;

            always_comb begin
                pc_d = pc_q;
                if (Clr) begin
                    pc_d = '0;
                end else if (En) begin
                    pc_d = (pc_q == LAST) ? '0 : pc_q + 1'b1;
                end
            end

            // Disabled cycles leave pc where it is so a resumed count finishes its period.
            assign Tick = En & (pc_q == LAST);

            always_ff @(posedge Clock or negedge Resetn) begin
                if (!Resetn) begin
                    pc_q <= '0;
                end else begin
                    pc_q <= pc_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/param_counter.sv
// Prescaled modulo up/down counter with load, terminal-count pulse and wrap/saturate/one-shot modes.
module param_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int MAX       = 1023,
    parameter int PRESCALE  = 1,
    parameter int RESET_VAL = 0
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             En,
    input  logic             Up,
    input  logic [1:0]       Mode,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             Tc,
    output logic             Done
);

    generate
        if (MAX < 1 || MAX > (2 ** WIDTH) - 1) begin : g_bad_max
            $error("param_counter: MAX out of range for WIDTH");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("param_counter: PRESCALE must be at least 1");
        end
        if (RESET_VAL < 0 || RESET_VAL > MAX) begin : g_bad_reset_val
            $error("param_counter: RESET_VAL must lie in 0..MAX");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic             tick;
    logic [WIDTH-1:0] term;

    prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .Clock (Clock),
        .Resetn(Resetn),
        .En    (En & (state_q == RUN)),
        .Clr   (Load),
        .Tick  (tick)
    );

    assign term = Up ? MAX_V : '0;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        tc_d    = 1'b0;
        done_d  = done_q;
        if (Load) begin
            q_d     = (D > MAX_V) ? MAX_V : D;
            state_d = RUN;
            done_d  = 1'b0;
        end else if (state_q == DONE) begin
            if (Mode != ONESHOT) begin
                state_d = RUN;
                done_d  = 1'b0;
            end
        end else if (tick) begin
            if (q_q == term) begin
                tc_d = 1'b1;
                // Mode 3 is unassigned and falls into the wrap branch.
                case (Mode)
                    SAT: q_d = q_q;
                    ONESHOT: begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                    default: q_d = Up ? '0 : MAX_V;
                endcase
            end else begin
                q_d = Up ? q_q + 1'b1 : q_q - 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= RUN;
            q_q     <= RESET_V;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign Q    = q_q;
    assign Tc   = tc_q;
    assign Done = done_q;

endmodule

// File: tb/tb_param_counter.sv
// Directed checks of param_counter with WIDTH=4, MAX=9, PRESCALE=3.
module tb_param_counter;

    logic       Clock;
    logic       Resetn;
    logic       En;
    logic       Up;
    logic [1:0] Mode;
    logic       Load;
    logic [3:0] D;
    logic [3:0] Q;
    logic       Tc;
    logic       Done;

    int tests_run;
    int tests_failed;

    param_counter #(
        .WIDTH(4),
        .MAX(9),
        .PRESCALE(3),
        .RESET_VAL(0)
    ) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .En    (En),
        .Up    (Up),
        .Mode  (Mode),
        .Load  (Load),
        .D     (D),
        .Q     (Q),
        .Tc    (Tc),
        .Done  (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic load(input logic [3:0] d);
        Load = 1'b1;
        D    = d;
        step(1);
        Load = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        Resetn = 1'b0;
        En     = 1'b1;
        Up     = 1'b1;
        Mode   = 2'd0;
        Load   = 1'b0;
        D      = 4'd0;

        // Reset and wrap up
        step(3);
        check("reset_q", Q, 0);
        check("reset_tc", Tc, 0);
        check("reset_done", Done, 0);
        Resetn = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step(3);
            check($sformatf("up_q%0d", k), Q, k);
            check($sformatf("up_tc%0d", k), Tc, 0);
        end
        step(3);
        check("up_wrap_q", Q, 0);
        check("up_wrap_tc", Tc, 1);
        check("up_wrap_done", Done, 0);
        step(1);
        check("up_wrap_tc_end", Tc, 0);

        // Down wrap
        Up = 1'b0;
        load(4'd2);
        check("dn_load_q", Q, 2);
        step(3); check("dn_q1", Q, 1);
        step(3); check("dn_q0", Q, 0); check("dn_tc0", Tc, 0);
        step(3); check("dn_wrap_q", Q, 9); check("dn_wrap_tc", Tc, 1);

        // Down saturate
        Mode = 2'd1;
        load(4'd2);
        step(6); check("sat_q0", Q, 0); check("sat_tc_pre", Tc, 0);
        step(3); check("sat_hold_q", Q, 0); check("sat_tc1", Tc, 1);
        step(1); check("sat_tc_low", Tc, 0);
        step(2); check("sat_hold_q2", Q, 0); check("sat_tc2", Tc, 1);

        // One-shot
        Up   = 1'b1;
        Mode = 2'd2;
        load(4'd7);
        step(3); check("os_q8", Q, 8);
        step(3); check("os_q9", Q, 9); check("os_tc_pre", Tc, 0); check("os_done_pre", Done, 0);
        step(3); check("os_q_end", Q, 9); check("os_tc", Tc, 1); check("os_done", Done, 1);
        step(1); check("os_tc_once", Tc, 0);
        step(32); check("os_hold_q", Q, 9); check("os_hold_done", Done, 1); check("os_hold_tc", Tc, 0);
        load(4'd0);
        check("os_reload_q", Q, 0); check("os_reload_done", Done, 0);
        step(3); check("os_resume_q", Q, 1);

        // Load clamp and priority over a terminal tick
        Mode = 2'd0;
        load(4'd15);
        check("clamp_q", Q, 9);
        step(2);
        load(4'd4);
        check("prio_q", Q, 4); check("prio_tc", Tc, 0);
        step(1); check("prio_tc_next", Tc, 0);

        // Enable freeze mid-prescale
        load(4'd5);
        step(1);
        En = 1'b0;
        step(10); check("frz_q", Q, 5);
        En = 1'b1;
        step(1); check("frz_resume1", Q, 5);
        step(1); check("frz_resume2", Q, 6); check("frz_done", Done, 0);

        // Asynchronous reset between edges at Q=6
        #2 Resetn = 1'b0;
        #1;
        check("arst_q", Q, 0); check("arst_tc", Tc, 0);
        step(1);
        Resetn = 1'b1;

        // Asynchronous reset while in DONE
        Mode = 2'd2;
        load(4'd9);
        step(3); check("arst2_done_pre", Done, 1); check("arst2_tc_pre", Tc, 1);
        #2 Resetn = 1'b0;
        #1;
        check("arst2_done", Done, 0); check("arst2_q", Q, 0); check("arst2_tc", Tc, 0);
        step(1);
        Resetn = 1'b1;

        // Leaving DONE by mode change
        load(4'd9);
        step(3); check("mode_done", Done, 1);
        Mode = 2'd0;
        step(1); check("mode_run", Done, 0); check("mode_q", Q, 9);
        step(3); check("mode_wrap_q", Q, 0); check("mode_wrap_tc", Tc, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
